// File: rtl/toaplan2_cen_ctrl_pkg.sv
// Shared types and constants for the Toaplan2 fractional clock-enable scheduler.
// Holds the channel map, datapath widths, ratio pair and config FSM encoding.
package toaplan2_cen_pkg;

  localparam int NUM_CH   = 4;
  localparam int CH_VIDEO = 0;
  localparam int CH_OKI   = 1;
  localparam int CH_FM    = 2;
  localparam int CH_AUX   = 3;

  localparam int RATIO_W  = 16;
  localparam int ACC_W    = 17;

  typedef struct packed {
    logic [RATIO_W-1:0] n;
    logic [RATIO_W-1:0] m;
  } ratio_t;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_EDGE
  } cfg_state_t;

  // A ratio is usable when the denominator is nonzero and the rate does not exceed 1.
  function automatic logic ratio_legal(ratio_t r);
    return (r.m != '0) && (r.n <= r.m);
  endfunction

endpackage

// File: rtl/toaplan2_cen_ctrl_if.sv
// Config, pause and enable bundle between the host side and the scheduler.
// master drives requests and watches enables; slave is the scheduler.
interface toaplan2_cen_ctrl_if;

  logic                                  CFG_VALID;
  logic                                  CFG_READY;
  logic [1:0]                            CFG_SEL;
  logic [toaplan2_cen_pkg::RATIO_W-1:0]  CFG_N;
  logic [toaplan2_cen_pkg::RATIO_W-1:0]  CFG_M;
  logic                                  CFG_ERR;
  logic                                  PAUSE_REQ;
  logic [toaplan2_cen_pkg::NUM_CH-1:0]   PAUSE_MASK;
  logic                                  PAUSE_ACK;
  logic [toaplan2_cen_pkg::NUM_CH-1:0]   CEN;
  logic [toaplan2_cen_pkg::NUM_CH-1:0]   CEN_DIV2;
  logic [toaplan2_cen_pkg::NUM_CH-1:0]   CEN_DIV4;

  modport master (
    output CFG_VALID, CFG_SEL, CFG_N, CFG_M, PAUSE_REQ, PAUSE_MASK,
    input  CFG_READY, CFG_ERR, PAUSE_ACK, CEN, CEN_DIV2, CEN_DIV4
  );

  modport slave (
    input  CFG_VALID, CFG_SEL, CFG_N, CFG_M, PAUSE_REQ, PAUSE_MASK,
    output CFG_READY, CFG_ERR, PAUSE_ACK, CEN, CEN_DIV2, CEN_DIV4
  );

endinterface

// File: rtl/toaplan2_cen_ctrl_chan.sv
// One fractional N/M enable channel: accumulator, /2 and /4 pulse taps, freeze and ratio load.
// Enables are registered (one cycle after the deciding edge); boundary is combinational.
module toaplan2_cen_chan
  import toaplan2_cen_pkg::*;
#(
  parameter int unsigned RST_N = 1,
  parameter int unsigned RST_M = 1
) (
  input  logic   CLK96,
  input  logic   RESETn,
  input  logic   freeze,
  input  logic   load,
  input  ratio_t load_ratio,
  output logic   boundary,
  output logic   stopped,
  output logic   cen,
  output logic   cen_div2,
  output logic   cen_div4
);

  ratio_t             ratio;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   sum;
  logic [1:0]         phase;

  assign sum      = acc + {1'b0, ratio.n};
  assign boundary = (sum >= {1'b0, ratio.m});
  assign stopped  = (ratio.n == '0);

  always_ff @(posedge CLK96 or negedge RESETn) begin
    if (!RESETn) begin
      ratio    <= '{n: RATIO_W'(RST_N), m: RATIO_W'(RST_M)};
      acc      <= '0;
      phase    <= '0;
      cen      <= 1'b0;
      cen_div2 <= 1'b0;
      cen_div4 <= 1'b0;
    end else begin
      if (freeze) begin
        cen      <= 1'b0;
        cen_div2 <= 1'b0;
        cen_div4 <= 1'b0;
      end else begin
        cen      <= boundary;
        cen_div2 <= boundary & phase[0];
        cen_div4 <= boundary & (phase == 2'b11);
        phase    <= phase + {1'b0, boundary};
        acc      <= boundary ? (sum - {1'b0, ratio.m}) : sum;
      end
      // A load restarts the period under the new ratio; the pulse above still used the old one.
      if (load) begin
        acc   <= '0;
        ratio <= load_ratio;
      end
    end
  end

endmodule

// File: rtl/toaplan2_cen_ctrl.sv
// Four-channel CLK96 enable scheduler with boundary-aligned ratio updates and masked pause.
// One update may be outstanding; CFG_READY is low from acceptance until the apply edge.
module toaplan2_cen_ctrl
  import toaplan2_cen_pkg::*;
#(
  parameter int unsigned N0 = 9,
  parameter int unsigned M0 = 64,
  parameter int unsigned N1 = 1,
  parameter int unsigned M1 = 24,
  parameter int unsigned N2 = 9,
  parameter int unsigned M2 = 128,
  parameter int unsigned N3 = 0,
  parameter int unsigned M3 = 1
) (
  input  logic                 CLK96,
  input  logic                 RESETn,
  toaplan2_cen_ctrl_if.slave   bus
);

  localparam int unsigned RST_N_TAB [NUM_CH] = '{N0, N1, N2, N3};
  localparam int unsigned RST_M_TAB [NUM_CH] = '{M0, M1, M2, M3};

  cfg_state_t          state;
  logic                ready_q;
  logic                err_q;
  logic                ack_q;
  logic [1:0]          pend_sel;
  ratio_t              pend_ratio;
  ratio_t              req;

  logic [NUM_CH-1:0]   freeze;
  logic [NUM_CH-1:0]   load;
  logic [NUM_CH-1:0]   boundary;
  logic [NUM_CH-1:0]   stopped;
  logic [NUM_CH-1:0]   cen;
  logic [NUM_CH-1:0]   cen_div2;
  logic [NUM_CH-1:0]   cen_div4;

  assign req    = '{n: bus.CFG_N, m: bus.CFG_M};
  assign freeze = bus.PAUSE_REQ ? bus.PAUSE_MASK : '0;

  // Stopped or frozen targets have no boundary to wait for, so they take the update at once.
  always_comb begin
    load = '0;
    if (state == ST_WAIT_EDGE)
      load[pend_sel] = boundary[pend_sel] | stopped[pend_sel] | freeze[pend_sel];
  end

  always_ff @(posedge CLK96 or negedge RESETn) begin
    if (!RESETn) begin
      state      <= ST_IDLE;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
      ack_q      <= 1'b0;
      pend_sel   <= '0;
      pend_ratio <= '0;
    end else begin
      ack_q <= bus.PAUSE_REQ;
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.CFG_VALID && ready_q) begin
            if (ratio_legal(req)) begin
              pend_sel   <= bus.CFG_SEL;
              pend_ratio <= req;
              ready_q    <= 1'b0;
              state      <= ST_WAIT_EDGE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_WAIT_EDGE: begin
          if (|load) begin
            ready_q <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    toaplan2_cen_chan #(
      .RST_N (RST_N_TAB[g]),
      .RST_M (RST_M_TAB[g])
    ) u_chan (
      .CLK96      (CLK96),
      .RESETn     (RESETn),
      .freeze     (freeze[g]),
      .load       (load[g]),
      .load_ratio (pend_ratio),
      .boundary   (boundary[g]),
      .stopped    (stopped[g]),
      .cen        (cen[g]),
      .cen_div2   (cen_div2[g]),
      .cen_div4   (cen_div4[g])
    );
  end

  assign bus.CFG_READY = ready_q;
  assign bus.CFG_ERR   = err_q;
  assign bus.PAUSE_ACK = ack_q;
  assign bus.CEN       = cen;
  assign bus.CEN_DIV2  = cen_div2;
  assign bus.CEN_DIV4  = cen_div4;

endmodule

// File: doc/toaplan2_cen_ctrl.md
Name: toaplan2_cen_ctrl

Overview:
- Runtime-configurable clock-enable scheduler for the Toaplan2 core. Four fractional N/M channels run off CLK96: video, OKI, FM, auxiliary.
- Channel ratios can be reprogrammed over a valid/ready port, for per-game clock tables loaded at boot. Each update is applied only on that channel's period boundary, so no enable pulse is short or doubled.
- A pause request/acknowledge handshake freezes selected channels for pause and savestate support.

Parameters:
- N0, 9, channel 0 numerator (96×9/64 = 13.5 MHz, video)
- M0, 64, channel 0 denominator
- N1, 1, channel 1 numerator (96/24 = 4 MHz, OKI)
- M1, 24, channel 1 denominator
- N2, 9, channel 2 numerator (96×9/128 = 6.75 MHz, FM base)
- M2, 128, channel 2 denominator
- N3, 0, channel 3 numerator (0 = stopped, auxiliary)
- M3, 1, channel 3 denominator

Ports:
- CLK96  in  1  96 MHz clock; the only clock
- RESETn  in  1  asynchronous, active-low reset
- CFG_VALID  in  1  config request
- CFG_READY  out  1  config port can accept
- CFG_SEL  in  2  target channel
- CFG_N  in  16  new numerator
- CFG_M  in  16  new denominator
- CFG_ERR  out  1  one-cycle pulse: request rejected
- PAUSE_REQ  in  1  freeze request
- PAUSE_MASK  in  4  channels affected by the pause
- PAUSE_ACK  out  1  masked channels are frozen
- CEN  out  4  per-channel enable, 1-cycle pulses
- CEN_DIV2  out  4  every 2nd CEN pulse of the channel
- CEN_DIV4  out  4  every 4th CEN pulse of the channel

Behaviour:
- Reset (async, RESETn=0): N/M load from the parameters, accumulators = 0, DIV phase counters = 0. CEN, CEN_DIV2, CEN_DIV4, CFG_ERR, PAUSE_ACK = 0. CFG_READY = 1. Any pending update is dropped. Release mid-operation restarts every channel from accumulator 0.
- Per channel, each posedge when running: sum = acc + N (17-bit).
  - sum ≥ M: acc ← sum − M, CEN ← 1.
  - Otherwise: acc ← sum, CEN ← 0.
  - With N=1, M=24 from reset, the first pulse occurs on the 24th edge, then one every 24 cycles.
- DIV outputs: a 2-bit phase counter increments on each CEN pulse.
  - CEN_DIV2 is registered with CEN when phase[0]=1.
  - CEN_DIV4 is registered with CEN when phase=3.
- N=0: the channel never pulses; acc holds.
- Legal config: M ≠ 0 and N ≤ M.
  - N = M gives CEN high every cycle.
  - N=0 is legal (stop).
- Config handshake:
  - Transfer occurs on a cycle with CFG_VALID & CFG_READY.
  - Illegal request: CFG_ERR pulses next cycle, nothing changes, CFG_READY stays 1.
  - Legal request: values are latched into the target's pending slot, and CFG_READY drops the next cycle (one outstanding update total).
- Pending state machine, states IDLE → WAIT_EDGE → IDLE:
  - In WAIT_EDGE, apply on the first edge where the target's sum ≥ M. That edge still emits its CEN (and DIV) pulse using the old ratio; acc ← 0; N, M ← new values.
  - If the target currently has N=0 or is paused, apply on the next edge instead, with no pulse.
  - CFG_READY returns to 1 the cycle after the apply edge.
  - A request accepted on the same edge the channel pulses waits for the following boundary.
- Pause:
  - A channel is frozen while PAUSE_REQ=1 and its PAUSE_MASK bit is 1. A frozen channel has CEN/DIV outputs forced 0 and acc/phase held; it is effective from the edge after PAUSE_REQ rises.
  - PAUSE_ACK is registered: it equals the PAUSE_REQ value from the previous edge.
  - Mask changes while PAUSE_REQ=1 take effect on the next edge; ACK stays 1.
  - Unfreeze resumes from the held acc, so no phase is lost.
- Unmasked channels are never disturbed by pause or by config aimed at another channel.

Decomposition:
- Package toaplan2_cen_pkg holds:
  - channel index constants CH_VIDEO=0, CH_OKI=1, CH_FM=2, CH_AUX=3
  - NUM_CH=4
  - RATIO_W=16, ACC_W=17
  - a typedef for the {N, M} ratio pair
- One sub-module, toaplan2_cen_chan, instantiated four times. Its contents:
  - accumulator, compare/subtract
  - DIV phase counter
  - freeze input
  - load strobe with new ratio
  - boundary flag output
- The top level holds the config port, legality check, pending slot and state machine, and pause/ACK logic.

Test Plan:
- Reset release, no config → within 768 cycles: ch0 gives 108 CEN pulses (9/64); ch1 gives 32 CEN, 16 DIV2, 8 DIV4; ch2 gives 54; ch3 gives 0.
- CFG ch1 N=1 M=32 accepted mid-period → ch1 pulses once more at its old 24-cycle spacing. CFG_READY stays 0 until the cycle after that pulse. The next pulse comes exactly 32 cycles later; no pulse gap < 24.
- CFG N=5 M=4, then M=0 → each gives a CFG_ERR 1-cycle pulse; CFG_READY stays 1; the target ratio is unchanged.
- CFG ch3 N=1 M=2 while ch3 is stopped → applied the next cycle; CEN[3] then toggles every 2 cycles.
- PAUSE_REQ=1 with MASK=0b0010 for 100 cycles → ACK is 1 one cycle later; CEN[1]=0 throughout; other channels keep their unchanged counts. After release, the first ch1 pulse comes at the remaining held-acc distance.
- RESETn asserted mid-WAIT_EDGE with PAUSE_REQ high → all outputs are 0 at once and CFG_READY=1. After release, defaults are restored and the pending update is discarded.
